// File: rtl/jtag_rx_fifo.sv
// ECP5 JTAGG user chain 2: host-written bytes land in a small show-ahead FIFO
// drained by a valid/ready consumer; capture-DR reports FIFO status.
module jtag_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE2,
  output logic              JTD2,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [4:0]        fifo_count
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [15:0]       shift_q, shift_d;
  logic              jtd2_q, jtd2_d;
  logic              armed_q, armed_d;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic        full_s, empty_s, upd_s, push_s, clr_s, pop_s, wr_s, drop_s;
  logic [15:0] status_s;

  assign full_s   = (count_q == DEPTH_C);
  assign empty_s  = (count_q == 5'd0);
  assign status_s = {ovf_q, full_s, empty_s, count_q, 8'h00};
  // Only an update that follows our own shift belongs to this chain.
  assign upd_s    = JUPDATE & armed_q;
  assign push_s   = upd_s & shift_q[15];
  assign clr_s    = upd_s & shift_q[14];
  assign pop_s    = ~empty_s & rd_ready;
  assign wr_s     = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;

  // Next-state for the DR, FIFO pointers, occupancy and overflow flag.
  always_comb begin
    shift_d = shift_q;
    jtd2_d  = jtd2_q;
    armed_d = armed_q;
    if (JCE2) begin
      if (JSHIFT) begin
        jtd2_d  = shift_q[0];
        shift_d = {JTDI, shift_q[15:1]};
        armed_d = 1'b1;
      end else begin
        shift_d = status_s;
      end
    end else begin
      shift_d = shift_q;
    end
    if (upd_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_d;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    wptr_d  = wr_s  ? (wptr_q + AW'(1'b1)) : wptr_q;
    rptr_d  = pop_s ? (rptr_q + AW'(1'b1)) : rptr_q;
    count_d = count_q + {4'd0, wr_s} - {4'd0, pop_s};
  end

  // State registers; a reset mid-frame discards the partial frame.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      shift_q <= 16'h0000;
      jtd2_q  <= 1'b0;
      armed_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      jtd2_q  <= jtd2_d;
      armed_q <= armed_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge JTCK) begin
    if (wr_s) begin
      mem_q[wptr_q] <= shift_q[DATA_W-1:0];
    end
  end

  assign JTD2       = jtd2_q;
  assign fifo_count = count_q;
  assign rd_valid   = ~empty_s;
  assign rd_data    = empty_s ? {DATA_W{1'b0}} : mem_q[rptr_q];

endmodule

// File: tb/tb_jtag_rx_fifo.sv
// Scoreboard bench for jtag_rx_fifo: a queue-based model predicts popped bytes,
// occupancy and capture status; a monitor compares them as the DUT produces them.
module tb_jtag_rx_fifo;
  localparam int DEPTH = 16;

  logic       JTCK = 1'b0;
  logic       JRSTN, JTDI, JSHIFT, JUPDATE, JCE2, JTD2, rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic        cap_now, upd_now;
  logic [15:0] upd_frame, last_frame, st;
  bit          armed_b;
  int          mcount = 0;
  bit          movf = 1'b0;
  bit          m_pop, m_acc, m_drop;
  logic [7:0]  exp_q[$];
  logic [15:0] stat_q[$];
  bit          rr_rand;
  int          rr_pct;
  logic        rr_dir;

  jtag_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE2(JCE2), .JTD2(JTD2), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_count(fifo_count)
  );

  always #5 JTCK = ~JTCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no expected entry, required one at %0t", name, $time);
  endtask

  // Reference model: FIFO as an occupancy count plus a queue of expected bytes.
  initial begin
    forever begin
      @(posedge JTCK or negedge JRSTN);
      if (JRSTN !== 1'b1) begin
        mcount = 0;
        movf   = 1'b0;
        exp_q.delete();
        stat_q.delete();
      end else begin
        m_pop  = (rd_ready === 1'b1) && (mcount > 0);
        m_acc  = 1'b0;
        m_drop = 1'b0;
        if (cap_now)
          stat_q.push_back({movf, mcount == DEPTH, mcount == 0, 5'(mcount), 8'h00});
        if (upd_now && upd_frame[15]) begin
          if (mcount < DEPTH || m_pop) begin
            m_acc = 1'b1;
            exp_q.push_back(upd_frame[7:0]);
          end else begin
            m_drop = 1'b1;
          end
        end
        if (m_drop) movf = 1'b1;
        else if (upd_now && upd_frame[14]) movf = 1'b0;
        mcount = mcount + int'(m_acc) - int'(m_pop);
      end
    end
  end

  // Monitor: sampled just before each rising edge.
  initial begin
    forever begin
      @(negedge JTCK);
      #4;
      if (JRSTN === 1'b1) begin
        chk("count", 32'(fifo_count), 32'(mcount));
        chk("rd_valid", 32'(rd_valid), 32'(mcount != 0));
        if (rd_valid !== 1'b1) chk("rd_data_empty", 32'(rd_data), 32'h0);
        else if (rd_ready === 1'b1) begin
          if (exp_q.size() == 0) fail("pop_unexpected");
          else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Consumer ready: random or directed.
  initial begin
    forever begin
      @(negedge JTCK);
      #1;
      rd_ready = rr_rand ? (int'($urandom_range(0, 99)) < rr_pct) : rr_dir;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic shift_frame(input logic [15:0] f, output logic [15:0] s);
    @(negedge JTCK);
    JCE2 = 1'b1; JSHIFT = 1'b0; cap_now = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge JTCK);
      cap_now = 1'b0; JSHIFT = 1'b1; JTDI = f[i];
      if (i > 0) s[i-1] = JTD2;
    end
    @(negedge JTCK);
    JCE2 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    s[15] = JTD2;
    armed_b = 1'b1;
    last_frame = f;
    if (stat_q.size() == 0) fail("status_missing");
    else chk("status", 32'(s), 32'(stat_q.pop_front()));
  endtask

  task automatic update(input logic rdy);
    @(negedge JTCK);
    JUPDATE = 1'b1; upd_now = armed_b; upd_frame = last_frame; armed_b = 1'b0; rr_dir = rdy;
    @(negedge JTCK);
    JUPDATE = 1'b0; upd_now = 1'b0; rr_dir = 1'b0;
  endtask

  task automatic drain(input int n);
    @(negedge JTCK);
    rr_dir = 1'b1;
    repeat (n) @(negedge JTCK);
    rr_dir = 1'b0;
  endtask

  initial begin
    JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE2 = 1'b0; rd_ready = 1'b0;
    cap_now = 1'b0; upd_now = 1'b0; armed_b = 1'b0; upd_frame = 16'h0; last_frame = 16'h0;
    rr_rand = 1'b0; rr_pct = 50; rr_dir = 1'b0;
    repeat (2) @(negedge JTCK);
    chk("reset_jtd2", 32'(JTD2), 32'h0);
    chk("reset_valid", 32'(rd_valid), 32'h0);
    chk("reset_data", 32'(rd_data), 32'h0);
    chk("reset_count", 32'(fifo_count), 32'h0);
    @(negedge JTCK);
    JRSTN = 1'b1;

    shift_frame(16'h0000, st);
    chk("empty_status", 32'(st), 32'h2000);

    shift_frame(16'h80A5, st);
    update(1'b0);
    #2;
    chk("a5_valid", 32'(rd_valid), 32'h1);
    chk("a5_data", 32'(rd_data), 32'hA5);
    chk("a5_count", 32'(fifo_count), 32'h1);
    @(negedge JTCK); rr_dir = 1'b1;
    @(negedge JTCK); rr_dir = 1'b0;
    #2;
    chk("a5_popped_valid", 32'(rd_valid), 32'h0);
    chk("a5_popped_data", 32'(rd_data), 32'h0);

    for (int k = 1; k <= 16; k++) begin
      shift_frame({8'h80, 8'(k)}, st);
      update(1'b0);
    end
    #2 chk("full_count", 32'(fifo_count), 32'd16);
    shift_frame(16'h8011, st);
    chk("full_status", 32'(st), 32'h5000);
    update(1'b0);
    shift_frame(16'h4000, st);
    chk("ovf_status", 32'(st), 32'hD000);
    update(1'b0);
    shift_frame(16'h8077, st);
    chk("ovf_cleared_status", 32'(st), 32'h5000);
    update(1'b1);
    #2 chk("full_pushpop_count", 32'(fifo_count), 32'd16);
    shift_frame(16'h0000, st);
    chk("no_ovf_status", 32'(st), 32'h5000);
    drain(20);

    shift_frame(16'h80FF, st);
    update(1'b0);
    update(1'b0);
    #2 chk("unarmed_count", 32'(fifo_count), 32'h1);
    drain(3);

    shift_frame(16'h8031, st); update(1'b0);
    shift_frame(16'h8032, st); update(1'b0);
    @(negedge JTCK); JCE2 = 1'b1; JSHIFT = 1'b0; cap_now = 1'b1;
    @(negedge JTCK); cap_now = 1'b0; JSHIFT = 1'b1; JTDI = 1'b1;
    repeat (10) @(negedge JTCK);
    chk("midshift_jtd2", 32'(JTD2), 32'h1);
    #2 JRSTN = 1'b0;
    #1;
    chk("rst_jtd2", 32'(JTD2), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_valid", 32'(rd_valid), 32'h0);
    @(negedge JTCK); JCE2 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0; armed_b = 1'b0;
    @(negedge JTCK); JRSTN = 1'b1;
    update(1'b0);
    #2 chk("post_rst_update_count", 32'(fifo_count), 32'h0);

    rr_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [15:0] f;
      rr_pct = (n < 40) ? 50 : 1;
      f = {$urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 6'($urandom), 8'($urandom)};
      shift_frame(f, st);
      if ($urandom_range(0, 7) == 0) @(negedge JTCK);
      update(1'b0);
      if ($urandom_range(0, 9) == 0) update(1'b0);
    end
    rr_rand = 1'b0;
    drain(2 * DEPTH + 4);
    chk("final_exp_empty", 32'(exp_q.size()), 32'h0);
    chk("final_count", 32'(fifo_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_rx_fifo.md
Name: jtag_rx_fifo

Overview:
- Second user-chain data register (ECP5 JTAGG chain 2) that lets the host push bytes into a small FIFO in the JTCK domain.
- Each update-DR frame with the push flag set enqueues one byte.
- Capture-DR returns FIFO status to the host.
- A downstream consumer (LED/display logic, command decoder) drains the FIFO with a valid/ready handshake.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..16.
DATA_W, 8, payload width; fixed at 8 by the frame format.

Ports:
JTCK  input  1  TAP clock; sole clock, all logic on posedge
JRSTN  input  1  asynchronous active-low reset
JTDI  input  1  serial data in from TAP
JSHIFT  input  1  shift-DR active
JUPDATE  input  1  update-DR pulse (shared by all user chains)
JCE2  input  1  chain-2 enable (capture/shift)
JTD2  output  1  serial data out to TAP, registered
rd_data  output  8  FIFO head byte; 0 when empty
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  consumer accepts head when rd_valid
fifo_count  output  5  current occupancy, 0..DEPTH

Behaviour:
- Reset (JRSTN low, async): shift_reg=0, JTD2=0, armed=0, rd/wr pointers=0, count=0, overflow=0; rd_valid=0, rd_data=0. Memory contents are not reset.
- Frame is a 16-bit shift register, LSB shifted out first.
- Update-frame fields: [15]=push, [14]=clr_ovf, [13:8] ignored, [7:0]=data.
- Capture value: [15]=overflow, [14]=full, [13]=empty, [12:8]=count, [7:0]=0x00.
- Posedge JTCK with JCE2=1 and JSHIFT=1: JTD2<=shift_reg[0]; shift_reg<={JTDI,shift_reg[15:1]}; armed<=1.
- Posedge JTCK with JCE2=1 and JSHIFT=0: capture; shift_reg<=status word sampled before this edge's pop/push.
- JCE2=0 and JUPDATE=0: shift_reg, JTD2 and armed hold.
- Posedge JTCK with JUPDATE=1 and armed=1: armed<=0.
  - If push: enqueue shift_reg[7:0].
  - If clr_ovf: overflow<=0.
  - push and clr_ovf may both be set; both take effect.
- JUPDATE with armed=0 (another chain's frame): no effect.
- Pop: rd_valid & rd_ready at a posedge advances the read pointer.
- rd_data = mem[rptr] (show-ahead) when count>0, else 0.
- rd_valid = (count!=0). It rises one cycle after the push edge.
- Push into a full FIFO:
  - Accepted if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow<=1 (sticky until clr_ovf or reset).
  - If clr_ovf is set in the dropping frame, overflow ends at 1 (set wins).
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push to an empty FIFO with rd_ready=1: no same-cycle bypass; the byte appears on the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full = count==DEPTH.
- Reset asserted mid-shift or mid-frame: everything returns to reset values immediately; the partial frame is discarded.

Test Plan:
- Reset, then capture+shift 16 bits of 0 -> JTD2 stream gives 0x2000 (empty=1, count=0); rd_valid=0.
- Shift frame 0x80A5 then JUPDATE -> next cycle rd_valid=1, rd_data=0xA5, fifo_count=1. Then rd_ready=1 for one cycle -> rd_valid=0, rd_data=0.
- Push 0x01..0x10 (16 frames, rd_ready=0) -> count=16; capture reads 0x5000 (full=1, count=16). Push 0x11 -> dropped; capture reads 0xD000. Drain reads 0x01..0x10 in order.
- After overflow, frame 0x4000 + update -> overflow=0, no enqueue; capture reads 0x5000 or the current status.
- Full FIFO, rd_ready=1 in the same cycle as JUPDATE of frame 0x8077 -> count stays 16, no overflow, 0x77 is read last after 15 more pops.
- JUPDATE without a prior JCE2 shift (armed=0), with shift_reg holding 0x80FF -> no enqueue. Reset asserted mid-shift -> JTD2=0 and count=0.
